// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MEMWAIT = 2'd1,
    HALT    = 2'd2
  } haz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam int MEM_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// rtl/pipe_hazard_ctrl_sat_counter.sv - haz_sat_counter: saturating, enable-gated, synchronously cleared counter
module haz_sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  // clear wins over count; count sticks at all-ones
  always_ff @(posedge clk) begin
    if (clr)
      count <= '0;
    else if (en && (count != {CNT_W{1'b1}}))
      count <= count + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush/freeze controller for the 5-stage pipeline (optional counters: HAZ_PERF_CNT_EN)
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_rt_i,
  input  logic [4:0]       IFID_rs_i,
  input  logic [4:0]       IFID_rt_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PC_write_o,
  output logic             IFID_write_o,
  output logic             IFID_flush_o,
  output logic             IDEX_write_o,
  output logic             IDEX_bubble_o,
  output logic             EXMEM_write_o,
  output logic             MEMWB_bubble_o,
  output logic             mem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [CNT_W-1:0] freeze_cnt_o
);

  // last wait count before the timeout trips
  localparam logic [7:0] WCNT_LAST = 8'(MEM_TIMEOUT - 1);

  haz_state_t state, state_nxt;
  logic [7:0] wcnt, wcnt_nxt;
  logic       err_nxt;
  logic       freeze;
  logic       lu;

  assign freeze = (state == HALT) | (mem_req_i & ~mem_ack_i);
  assign lu = IDEX_MemRead_i & (IDEX_rt_i != REG_ZERO) &
              ((IDEX_rt_i == IFID_rs_i) | (IDEX_rt_i == IFID_rt_i));

  // state, wait counter and sticky error flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= RUN;
      wcnt      <= 8'd0;
      mem_err_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      wcnt      <= wcnt_nxt;
      mem_err_o <= err_nxt;
    end
  end

  // memory-wait FSM next state; a withdrawn request or an ack both return to RUN
  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    err_nxt   = mem_err_o;
    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEMWAIT;
          wcnt_nxt  = 8'd1;
        end
      end
      MEMWAIT: begin
        if (!mem_req_i || mem_ack_i) begin
          state_nxt = RUN;
          wcnt_nxt  = 8'd0;
        end else if (wcnt == WCNT_LAST) begin
          state_nxt = HALT;
          err_nxt   = 1'b1;
        end else begin
          wcnt_nxt = wcnt + 8'd1;
        end
      end
      HALT:    state_nxt = HALT;
      default: state_nxt = RUN;
    endcase
  end

  // stage enables with priority reset > freeze > load-use > branch
  always_comb begin
    PC_write_o     = 1'b1;
    IFID_write_o   = 1'b1;
    IFID_flush_o   = 1'b0;
    IDEX_write_o   = 1'b1;
    IDEX_bubble_o  = 1'b0;
    EXMEM_write_o  = 1'b1;
    MEMWB_bubble_o = 1'b0;
    if (rst_i) begin
      PC_write_o = 1'b0;
    end else if (freeze) begin
      PC_write_o     = 1'b0;
      IFID_write_o   = 1'b0;
      IDEX_write_o   = 1'b0;
      EXMEM_write_o  = 1'b0;
      MEMWB_bubble_o = 1'b1;
    end else if (lu) begin
      PC_write_o    = 1'b0;
      IFID_write_o  = 1'b0;
      IDEX_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      IFID_flush_o = 1'b1;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic stall_en, freeze_en;
  assign stall_en  = ~rst_i & ~freeze & lu;
  assign freeze_en = ~rst_i & freeze;

  haz_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk(clk_i), .clr(rst_i), .en(stall_en), .count(stall_cnt_o)
  );
  haz_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk(clk_i), .clr(rst_i), .en(IFID_flush_o), .count(flush_cnt_o)
  );
  haz_sat_counter #(.CNT_W(CNT_W)) u_freeze_cnt (
    .clk(clk_i), .clr(rst_i), .en(freeze_en), .count(freeze_cnt_o)
  );
`else
  assign stall_cnt_o  = '0;
  assign flush_cnt_o  = '0;
  assign freeze_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_W = 32;
`ifdef HAZ_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {PC_w, IFID_w, IFID_flush, IDEX_w, IDEX_bubble, EXMEM_w, MEMWB_bubble}
  localparam logic [6:0] NORM = 7'b1101010;
  localparam logic [6:0] LU   = 7'b0001110;
  localparam logic [6:0] BR   = 7'b1111010;
  localparam logic [6:0] FRZ  = 7'b0000001;
  localparam logic [6:0] RST  = 7'b0101010;

  typedef struct {
    string      tag;
    logic [6:0] ctl;
    logic       err;
    int         st;
    int         fl;
    int         fz;
  } exp_t;

  exp_t sb[$];

  logic clk = 1'b0;
  logic rst, memread, br, req, ack;
  logic [4:0] idex_rt, ifid_rs, ifid_rt;
  logic pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .IDEX_MemRead_i(memread), .IDEX_rt_i(idex_rt),
    .IFID_rs_i(ifid_rs), .IFID_rt_i(ifid_rt),
    .branch_taken_i(br), .mem_req_i(req), .mem_ack_i(ack),
    .PC_write_o(pc_w), .IFID_write_o(ifid_w), .IFID_flush_o(ifid_f),
    .IDEX_write_o(idex_w), .IDEX_bubble_o(idex_b), .EXMEM_write_o(exmem_w),
    .MEMWB_bubble_o(memwb_b), .mem_err_o(mem_err),
    .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt), .freeze_cnt_o(freeze_cnt)
  );

  function automatic logic [CNT_W-1:0] ec(input int v);
    return PERF ? CNT_W'(v) : '0;
  endfunction

  task automatic step(input string tag, input logic r, input logic mr,
                      input logic [4:0] xrt, input logic [4:0] rs, input logic [4:0] rt,
                      input logic b, input logic rq, input logic ak,
                      input logic [6:0] c, input logic e, input int s, input int f, input int z);
    exp_t x;
    logic [6:0] obs;
    @(negedge clk);
    rst = r; memread = mr; idex_rt = xrt; ifid_rs = rs; ifid_rt = rt;
    br = b; req = rq; ack = ak;
    x.tag = tag; x.ctl = c; x.err = e; x.st = s; x.fl = f; x.fz = z;
    sb.push_back(x);
    #2;
    x = sb.pop_front();
    obs = {pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b};
    n_assert++;
    assert (obs === x.ctl) else begin
      n_fail++; $error("FAIL %s ctl observed=%b expected=%b", x.tag, obs, x.ctl);
    end
    n_assert++;
    assert (mem_err === x.err) else begin
      n_fail++; $error("FAIL %s mem_err observed=%b expected=%b", x.tag, mem_err, x.err);
    end
    n_assert++;
    assert (stall_cnt === ec(x.st)) else begin
      n_fail++; $error("FAIL %s stall_cnt observed=%0d expected=%0d", x.tag, stall_cnt, ec(x.st));
    end
    n_assert++;
    assert (flush_cnt === ec(x.fl)) else begin
      n_fail++; $error("FAIL %s flush_cnt observed=%0d expected=%0d", x.tag, flush_cnt, ec(x.fl));
    end
    n_assert++;
    assert (freeze_cnt === ec(x.fz)) else begin
      n_fail++; $error("FAIL %s freeze_cnt observed=%0d expected=%0d", x.tag, freeze_cnt, ec(x.fz));
    end
  endtask

  initial begin
    rst = 1'b1; memread = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    br = 1'b0; req = 1'b0; ack = 1'b0;
    @(negedge clk);
    // tag          rst mr rt     rs     rt     br rq ak  ctl   err st fl fz
    step("reset",     1, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, RST,  0, 0, 0, 0);
    step("idle0",     0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 0, 0, 0);
    step("lu_rs",     0, 1, 5'd8, 5'd8,  5'd3,  0, 0, 0, LU,   0, 0, 0, 0);
    step("lu_clear",  0, 0, 5'd8, 5'd8,  5'd3,  0, 0, 0, NORM, 0, 1, 0, 0);
    step("lu_r0",     0, 1, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 1, 0, 0);
    step("lu_br",     0, 1, 5'd9, 5'd2,  5'd9,  1, 0, 0, LU,   0, 1, 0, 0);
    step("br_retry",  0, 0, 5'd9, 5'd2,  5'd9,  1, 0, 0, BR,   0, 2, 0, 0);
    step("idle1",     0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 2, 1, 0);
    step("mw1",       0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 0);
    step("mw2",       0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 1);
    step("mw3",       0, 0, 5'd0, 5'd0,  5'd0,  1, 1, 0, FRZ,  0, 2, 1, 2);
    step("mw_ack",    0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 1, NORM, 0, 2, 1, 3);
    step("ack_noreq", 0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 1, NORM, 0, 2, 1, 3);
    step("frz_lu",    0, 1, 5'd7, 5'd7,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 3);
    step("frz_lu_ack",0, 0, 5'd7, 5'd7,  5'd0,  0, 1, 1, NORM, 0, 2, 1, 4);
    step("idle2",     0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 2, 1, 4);
    step("wd_frz",    0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 4);
    step("wd_drop",   0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 2, 1, 5);
    step("to1",       0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 5);
    step("to2",       0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 6);
    step("to3",       0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 7);
    step("to4",       0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 2, 1, 8);
    for (int i = 0; i < 10; i++)
      step("halt",    0, 1, 5'd4, 5'd4,  5'd0,  1, i[0], 1, FRZ, 1, 2, 1, 9 + i);
    step("rst_halt",  1, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, RST,  1, 2, 1, 19);
    step("post_rst",  0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 0, 0, 0);
    step("mw_again",  0, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, FRZ,  0, 0, 0, 0);
    step("rst_mw",    1, 0, 5'd0, 5'd0,  5'd0,  0, 1, 0, RST,  0, 0, 0, 1);
    step("post_rst2", 0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 0, 0, 0);
    step("lu_rt",     0, 1, 5'd5, 5'd1,  5'd5,  0, 0, 0, LU,   0, 0, 0, 0);
    step("lu_rt_end", 0, 0, 5'd0, 5'd0,  5'd0,  0, 0, 0, NORM, 0, 1, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
